// File: rtl/ntt_mem_scheduler_if.sv
// rtl/ntt_mem_scheduler_if.sv - address, read and write-back bus of the NTT memory scheduler
// Generator -> scheduler: in_valid, in_addr0, in_addr1, in_addr_tw, in_last.
// Scheduler -> memories/butterfly: rd_en, rd_addr0, rd_addr1, tw_rd_en, tw_addr,
//   bf_valid, wr_en, wr_addr0, wr_addr1; status: busy, done, err.
// raw_hazard is present only when NTT_RAW_HAZARD_CHECK_EN is defined.
// modport master: generator/bench side; modport slave: scheduler side.
interface ntt_mem_scheduler_if #(
  parameter int WIDTH_ADDR_BUTTERFLY = 8,
  parameter int WIDTH_ADDR_ZETAS     = 7
);
  logic                            in_valid;
  logic [WIDTH_ADDR_BUTTERFLY-1:0] in_addr0;
  logic [WIDTH_ADDR_BUTTERFLY-1:0] in_addr1;
  logic [WIDTH_ADDR_ZETAS-1:0]     in_addr_tw;
  logic                            in_last;
  logic                            rd_en;
  logic [WIDTH_ADDR_BUTTERFLY-1:0] rd_addr0;
  logic [WIDTH_ADDR_BUTTERFLY-1:0] rd_addr1;
  logic                            tw_rd_en;
  logic [WIDTH_ADDR_ZETAS-1:0]     tw_addr;
  logic                            bf_valid;
  logic                            wr_en;
  logic [WIDTH_ADDR_BUTTERFLY-1:0] wr_addr0;
  logic [WIDTH_ADDR_BUTTERFLY-1:0] wr_addr1;
  logic                            busy;
  logic                            done;
  logic                            err;
`ifdef NTT_RAW_HAZARD_CHECK_EN
  logic                            raw_hazard;
`endif

  modport master (
    output in_valid, in_addr0, in_addr1, in_addr_tw, in_last,
`ifdef NTT_RAW_HAZARD_CHECK_EN
    input  raw_hazard,
`endif
    input  rd_en, rd_addr0, rd_addr1, tw_rd_en, tw_addr, bf_valid,
    input  wr_en, wr_addr0, wr_addr1, busy, done, err
  );

  modport slave (
    input  in_valid, in_addr0, in_addr1, in_addr_tw, in_last,
`ifdef NTT_RAW_HAZARD_CHECK_EN
    output raw_hazard,
`endif
    output rd_en, rd_addr0, rd_addr1, tw_rd_en, tw_addr, bf_valid,
    output wr_en, wr_addr0, wr_addr1, busy, done, err
  );
endinterface

// File: rtl/ntt_mem_scheduler.sv
// rtl/ntt_mem_scheduler.sv - schedules coefficient/zeta reads and aligned write-back for an NTT butterfly
// Ports: clk (rising edge), rst_n (asynchronous, active-low),
//   bus (ntt_mem_scheduler_if.slave): generator beats in, RAM/ROM read and write
//   enables/addresses, butterfly operand strobe, busy/done/err status out.
// Optional: define NTT_RAW_HAZARD_CHECK_EN to compare each accepted beat against
//   in-flight beats and flag read-after-write hazards on raw_hazard and err.
module ntt_mem_scheduler #(
  parameter int WIDTH_ADDR_BUTTERFLY = 8,
  parameter int WIDTH_ADDR_ZETAS     = 7,
  parameter int RAM_RD_LATENCY       = 1,
  parameter int BF_LATENCY           = 4
) (
  input logic                clk,
  input logic                rst_n,
  ntt_mem_scheduler_if.slave bus
);
  // Stage 0 is the read-issue register; stage DEPTH is the write-back register.
  localparam int DEPTH = RAM_RD_LATENCY + BF_LATENCY;
  localparam int OCC_W = $clog2(DEPTH + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                          state_q, state_d;
  logic [DEPTH:0]                  pv_q, pv_d;
  logic [WIDTH_ADDR_BUTTERFLY-1:0] pa0_q [DEPTH+1];
  logic [WIDTH_ADDR_BUTTERFLY-1:0] pa0_d [DEPTH+1];
  logic [WIDTH_ADDR_BUTTERFLY-1:0] pa1_q [DEPTH+1];
  logic [WIDTH_ADDR_BUTTERFLY-1:0] pa1_d [DEPTH+1];
  logic [WIDTH_ADDR_ZETAS-1:0]     tw_q, tw_d;
  logic [OCC_W-1:0]                occ_q, occ_d;
  logic                            err_q, err_d;
  logic                            done_q, done_d;
  logic                            busy_q, busy_d;
  logic                            accept;
  logic                            hazard;

  assign accept = bus.in_valid && (state_q == IDLE || state_q == RUN);

  always_comb begin
    hazard = 1'b0;
`ifdef NTT_RAW_HAZARD_CHECK_EN
    // The beat in stage DEPTH is written this cycle, before the new read lands,
    // so only stages still ahead of write-back can hold stale data.
    for (int s = 0; s < DEPTH; s++) begin
      if (pv_q[s] && (bus.in_addr0 == pa0_q[s] || bus.in_addr0 == pa1_q[s] ||
                      bus.in_addr1 == pa0_q[s] || bus.in_addr1 == pa1_q[s])) begin
        hazard = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    pv_d     = {pv_q[DEPTH-1:0], accept};
    pa0_d[0] = accept ? bus.in_addr0 : pa0_q[0];
    pa1_d[0] = accept ? bus.in_addr1 : pa1_q[0];
    // Addresses advance only with a valid beat so every address output holds
    // its last issued value while its enable is low.
    for (int s = 1; s <= DEPTH; s++) begin
      pa0_d[s] = pv_q[s-1] ? pa0_q[s-1] : pa0_q[s];
      pa1_d[s] = pv_q[s-1] ? pa1_q[s-1] : pa1_q[s];
    end
    tw_d  = accept ? bus.in_addr_tw : tw_q;
    occ_d = occ_q + OCC_W'(accept) - OCC_W'(pv_q[DEPTH]);

    state_d = state_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid || bus.in_last) begin
          err_d   = 1'b0;
          state_d = bus.in_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (bus.in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.in_valid || bus.in_last) err_d = 1'b1;
        // Looking at the next occupancy lets done follow the final write by one cycle.
        if (occ_d == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (bus.in_valid || bus.in_last) err_d = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (accept && hazard) err_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pv_q    <= '0;
      for (int s = 0; s <= DEPTH; s++) begin
        pa0_q[s] <= '0;
        pa1_q[s] <= '0;
      end
      tw_q    <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pv_q    <= pv_d;
      for (int s = 0; s <= DEPTH; s++) begin
        pa0_q[s] <= pa0_d[s];
        pa1_q[s] <= pa1_d[s];
      end
      tw_q    <= tw_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.rd_en    = pv_q[0];
  assign bus.rd_addr0 = pa0_q[0];
  assign bus.rd_addr1 = pa1_q[0];
  assign bus.tw_rd_en = pv_q[0];
  assign bus.tw_addr  = tw_q;
  assign bus.bf_valid = pv_q[RAM_RD_LATENCY];
  assign bus.wr_en    = pv_q[DEPTH];
  assign bus.wr_addr0 = pa0_q[DEPTH];
  assign bus.wr_addr1 = pa1_q[DEPTH];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
`ifdef NTT_RAW_HAZARD_CHECK_EN
  assign bus.raw_hazard = accept && hazard;
`endif
endmodule

// File: tb/tb_ntt_mem_scheduler.sv
// tb/tb_ntt_mem_scheduler.sv - self-checking bench for ntt_mem_scheduler
module tb_ntt_mem_scheduler;
  localparam int RL    = 1;
  localparam int BFL   = 4;
  localparam int DEPTH = RL + BFL;
  localparam int NMAX  = 256;

  typedef struct packed {
    logic       rd;
    logic       tw_en;
    logic [7:0] ra0;
    logic [7:0] ra1;
    logic [6:0] tw;
    logic       bf;
    logic       wr;
    logic [7:0] wa0;
    logic [7:0] wa1;
    logic       busy;
    logic       done;
    logic       err;
    logic       hz;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic       s_v    [NMAX];
  logic       s_last [NMAX];
  logic [7:0] s_a0   [NMAX];
  logic [7:0] s_a1   [NMAX];
  logic [6:0] s_tw   [NMAX];
  logic       m_acc  [NMAX];
  logic       m_hz   [NMAX];
  logic       m_err  [NMAX];
  int         m_ph   [NMAX];
  obs_t       exp_a  [NMAX];
  obs_t       obs_a  [NMAX];

  ntt_mem_scheduler_if #(.WIDTH_ADDR_BUTTERFLY(8), .WIDTH_ADDR_ZETAS(7)) bus ();

  ntt_mem_scheduler #(
    .WIDTH_ADDR_BUTTERFLY(8),
    .WIDTH_ADDR_ZETAS(7),
    .RAM_RD_LATENCY(RL),
    .BF_LATENCY(BFL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.rd    = bus.rd_en;
    o.tw_en = bus.tw_rd_en;
    o.ra0   = bus.rd_addr0;
    o.ra1   = bus.rd_addr1;
    o.tw    = bus.tw_addr;
    o.bf    = bus.bf_valid;
    o.wr    = bus.wr_en;
    o.wa0   = bus.wr_addr0;
    o.wa1   = bus.wr_addr1;
    o.busy  = bus.busy;
    o.done  = bus.done;
    o.err   = bus.err;
`ifdef NTT_RAW_HAZARD_CHECK_EN
    o.hz    = bus.raw_hazard;
`else
    o.hz    = 1'b0;
`endif
    return o;
  endfunction

  // Reference model: decide which beats a transform accepts, then place each
  // accepted beat's read, operand strobe and write at fixed offsets from it.
  // Phases: 0 idle, 1 open, 2 closed/draining, 3 done cycle.
  function automatic void build_model(input int n);
    int         ph = 0;
    logic       err = 1'b0;
    int         done_at = -1;
    int         last_acc = -1;
    logic [7:0] ra0 = '0, ra1 = '0, wa0 = '0, wa1 = '0;
    logic [6:0] tw = '0;
    int         tb_i, tw_i;
    for (int c = 0; c < n; c++) begin
      m_ph[c]  = ph;
      m_err[c] = err;
      m_acc[c] = s_v[c] && (ph <= 1);
      m_hz[c]  = 1'b0;
`ifdef NTT_RAW_HAZARD_CHECK_EN
      if (m_acc[c]) begin
        for (int t = c - DEPTH; t < c; t++) begin
          if (t >= 0 && m_acc[t] && (s_a0[c] == s_a0[t] || s_a0[c] == s_a1[t] ||
                                     s_a1[c] == s_a0[t] || s_a1[c] == s_a1[t]))
            m_hz[c] = 1'b1;
        end
      end
`endif
      if (ph == 0 && (s_v[c] || s_last[c])) begin
        err = 1'b0;
        last_acc = -1;
      end
      if (ph >= 2 && (s_v[c] || s_last[c])) err = 1'b1;
      if (m_hz[c]) err = 1'b1;
      if (m_acc[c]) last_acc = c;
      if (ph <= 1 && s_last[c]) begin
        ph = 2;
        done_at = (last_acc >= 0) ? last_acc + DEPTH + 2 : c + 2;
      end else if (ph == 0 && s_v[c]) begin
        ph = 1;
      end else if (ph == 2 && c + 1 == done_at) begin
        ph = 3;
      end else if (ph == 3) begin
        ph = 0;
      end
    end
    for (int c = 0; c < n; c++) begin
      exp_a[c] = '0;
      if (c >= 1 && m_acc[c-1]) begin
        exp_a[c].rd    = 1'b1;
        exp_a[c].tw_en = 1'b1;
        ra0 = s_a0[c-1];
        ra1 = s_a1[c-1];
        tw  = s_tw[c-1];
      end
      tb_i = c - 1 - RL;
      if (tb_i >= 0 && m_acc[tb_i]) exp_a[c].bf = 1'b1;
      tw_i = c - 1 - DEPTH;
      if (tw_i >= 0 && m_acc[tw_i]) begin
        exp_a[c].wr = 1'b1;
        wa0 = s_a0[tw_i];
        wa1 = s_a1[tw_i];
      end
      exp_a[c].ra0  = ra0;
      exp_a[c].ra1  = ra1;
      exp_a[c].tw   = tw;
      exp_a[c].wa0  = wa0;
      exp_a[c].wa1  = wa1;
      exp_a[c].busy = (m_ph[c] != 0);
      exp_a[c].done = (m_ph[c] == 3);
      exp_a[c].err  = m_err[c];
      exp_a[c].hz   = m_hz[c];
    end
  endfunction

  task automatic clear_inputs();
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.in_addr0   = '0;
    bus.in_addr1   = '0;
    bus.in_addr_tw = '0;
  endtask

  task automatic clear_stim();
    for (int c = 0; c < NMAX; c++) begin
      s_v[c] = 1'b0;
      s_last[c] = 1'b0;
      s_a0[c] = '0;
      s_a1[c] = '0;
      s_tw[c] = '0;
    end
  endtask

  // Leaves time just after the first rising edge following release (cycle 0).
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_stim(input int n);
    for (int c = 0; c < n; c++) begin
      bus.in_valid   = s_v[c];
      bus.in_last    = s_last[c];
      bus.in_addr0   = s_a0[c];
      bus.in_addr1   = s_a1[c];
      bus.in_addr_tw = s_tw[c];
      @(negedge clk);
      obs_a[c] = sample();
      @(posedge clk);
      #1;
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    obs_t o;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_hold got %h exp 0", o);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_release got %h exp 0", o);
    end
  endtask

  task automatic test_single_beat();
    int n = 24;
    int en_cnt = 0;
    do_reset();
    clear_stim();
    s_v[10] = 1'b1; s_a0[10] = 8'h00; s_a1[10] = 8'h80; s_tw[10] = 7'd1;
    run_stim(n);
    build_model(n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL single_beat cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
      en_cnt += int'(obs_a[c].rd) + int'(obs_a[c].bf) + int'(obs_a[c].wr);
    end
    checks++;
    if (!(obs_a[11].rd === 1'b1 && obs_a[11].ra1 === 8'h80 && obs_a[11].tw === 7'd1)) begin
      errors++;
      $display("FAIL single_rd got rd=%b a1=%h tw=%h exp 1 80 01", obs_a[11].rd, obs_a[11].ra1, obs_a[11].tw);
    end
    checks++;
    if (obs_a[12].bf !== 1'b1) begin
      errors++;
      $display("FAIL single_bf got %b exp 1", obs_a[12].bf);
    end
    checks++;
    if (!(obs_a[16].wr === 1'b1 && obs_a[16].wa0 === 8'h00 && obs_a[16].wa1 === 8'h80)) begin
      errors++;
      $display("FAIL single_wr got wr=%b %h/%h exp 1 00/80", obs_a[16].wr, obs_a[16].wa0, obs_a[16].wa1);
    end
    checks++;
    if (en_cnt != 3) begin
      errors++;
      $display("FAIL single_enable_count got %0d exp 3", en_cnt);
    end
  endtask

  task automatic test_stream();
    int n = 145;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_cyc = -1;
    do_reset();
    clear_stim();
    for (int j = 0; j < 128; j++) begin
      s_v[j] = 1'b1; s_a0[j] = 8'(j); s_a1[j] = 8'(j + 128); s_tw[j] = 7'd1;
    end
    s_last[128] = 1'b1;
    run_stim(n);
    build_model(n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL stream cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
      rd_cnt += int'(obs_a[c].rd);
      wr_cnt += int'(obs_a[c].wr);
      if (obs_a[c].done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    checks++;
    if (rd_cnt != 128 || wr_cnt != 128) begin
      errors++;
      $display("FAIL stream_counts got rd=%0d wr=%0d exp 128 128", rd_cnt, wr_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 134) begin
      errors++;
      $display("FAIL stream_done got cnt=%0d cyc=%0d exp 1 134", done_cnt, done_cyc);
    end
    checks++;
    if (obs_a[134].busy !== 1'b1 || obs_a[135].busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_busy got %b%b exp 10", obs_a[134].busy, obs_a[135].busy);
    end
  endtask

  task automatic test_last_coincident();
    int n = 25;
    do_reset();
    clear_stim();
    for (int j = 0; j < 10; j++) begin
      s_v[j] = 1'b1; s_a0[j] = 8'($urandom); s_a1[j] = 8'($urandom); s_tw[j] = 7'($urandom);
    end
    s_last[9] = 1'b1;
    run_stim(n);
    build_model(n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL coincident cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
    end
    checks++;
    if (!(obs_a[15].wr === 1'b1 && obs_a[16].done === 1'b1 && obs_a[16].err === 1'b0)) begin
      errors++;
      $display("FAIL coincident_done got wr=%b done=%b err=%b exp 1 1 0", obs_a[15].wr, obs_a[16].done, obs_a[16].err);
    end
  endtask

  task automatic test_protocol_err();
    int n = 25;
    int rd_cnt = 0;
    do_reset();
    clear_stim();
    s_v[0] = 1'b1; s_a0[0] = 8'($urandom); s_a1[0] = 8'($urandom); s_tw[0] = 7'($urandom);
    s_last[2] = 1'b1;
    s_v[4] = 1'b1; s_a0[4] = 8'($urandom); s_a1[4] = 8'($urandom); s_tw[4] = 7'($urandom);
    s_v[10] = 1'b1; s_a0[10] = 8'($urandom); s_a1[10] = 8'($urandom); s_tw[10] = 7'($urandom);
    s_last[11] = 1'b1;
    run_stim(n);
    build_model(n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL protocol cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
      if (c < 10) rd_cnt += int'(obs_a[c].rd);
    end
    checks++;
    if (rd_cnt != 1) begin
      errors++;
      $display("FAIL protocol_drop got rd=%0d exp 1", rd_cnt);
    end
    checks++;
    if (!(obs_a[7].done === 1'b1 && obs_a[7].err === 1'b1 && obs_a[11].err === 1'b0)) begin
      errors++;
      $display("FAIL protocol_err got done=%b err=%b err_next=%b exp 1 1 0", obs_a[7].done, obs_a[7].err, obs_a[11].err);
    end
  endtask

  task automatic test_random();
    int n = 200;
    do_reset();
    clear_stim();
    for (int c = 0; c < 170; c++) begin
      s_v[c]    = ($urandom_range(0, 99) < 60);
      s_last[c] = ($urandom_range(0, 99) < 4);
      s_a0[c]   = 8'($urandom);
      s_a1[c]   = 8'($urandom);
      s_tw[c]   = 7'($urandom);
    end
    run_stim(n);
    build_model(n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL random cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    obs_t o;
    int wr_cnt = 0;
    do_reset();
    clear_stim();
    for (int j = 0; j < 5; j++) begin
      s_v[j] = 1'b1; s_a0[j] = 8'($urandom); s_a1[j] = 8'($urandom); s_tw[j] = 7'($urandom);
    end
    run_stim(8);
    build_model(8);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL midrun_pre cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
    end
    rst_n = 1'b0;
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL midrun_async got %h exp 0", o);
    end
    do_reset();
    clear_stim();
    run_stim(15);
    build_model(15);
    for (int c = 0; c < 15; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL midrun_post cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
      wr_cnt += int'(obs_a[c].wr);
    end
    checks++;
    if (wr_cnt != 0) begin
      errors++;
      $display("FAIL midrun_no_write got %0d exp 0", wr_cnt);
    end
  endtask

`ifdef NTT_RAW_HAZARD_CHECK_EN
  task automatic test_raw_hazard();
    int n = 20;
    int wr_cnt = 0;
    do_reset();
    clear_stim();
    s_v[2] = 1'b1; s_a0[2] = 8'h04; s_a1[2] = 8'h84; s_tw[2] = 7'd3;
    s_v[4] = 1'b1; s_a0[4] = 8'h14; s_a1[4] = 8'h04; s_tw[4] = 7'd5;
    s_last[6] = 1'b1;
    run_stim(n);
    build_model(n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL hazard cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
      wr_cnt += int'(obs_a[c].wr);
    end
    checks++;
    if (!(obs_a[2].hz === 1'b0 && obs_a[4].hz === 1'b1 && obs_a[5].err === 1'b1 && wr_cnt == 2)) begin
      errors++;
      $display("FAIL hazard_flag got hz2=%b hz4=%b err=%b wr=%0d exp 0 1 1 2", obs_a[2].hz, obs_a[4].hz, obs_a[5].err, wr_cnt);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single_beat();
    test_stream();
    test_last_coincident();
    test_protocol_err();
    test_random();
    test_reset_midrun();
`ifdef NTT_RAW_HAZARD_CHECK_EN
    test_raw_hazard();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
